// File: rtl/uart_pkg.sv
// Shared UART encodings, configuration payload and baud divisor helpers.
package uart_pkg;

  localparam int unsigned DIV_W = 16;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  // 2'b11 also means no parity
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic LEN_7  = 1'b0;
  localparam logic LEN_8  = 1'b1;
  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_t;

  typedef struct packed {
    logic       stop_bits;
    logic       data_length;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
  } uart_cfg_t;

  function automatic int unsigned baud_hz(input logic [1:0] b);
    case (b)
      BAUD_2400: return 2400;
      BAUD_4800: return 4800;
      BAUD_9600: return 9600;
      default:   return 19200;
    endcase
  endfunction

  // Rounded clocks per oversample tick
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned os,
                                           input logic [1:0]  b);
    int unsigned d;
    d = baud_hz(b) * os;
    return (clk_freq + d / 2) / d;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks for the chosen baud.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic       clear,
  output logic       tick
);

  localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, BAUD_2400));
  localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, BAUD_4800));
  localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, BAUD_9600));
  localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, BAUD_19200));

  logic [DIV_W-1:0] div_c;
  logic [DIV_W-1:0] cnt;

  // Divisor select
  always_comb begin
    div_c = DIV_19200;
    case (baud_rate)
      BAUD_2400: div_c = DIV_2400;
      BAUD_4800: div_c = DIV_4800;
      BAUD_9600: div_c = DIV_9600;
      default:   div_c = DIV_19200;
    endcase
  end

  // Divider counter with registered tick; clear restarts the phase
  always_ff @(posedge clock) begin
    if (!rst || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div_c - DIV_W'(1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_unit.sv
// UART receiver: 16x oversampled, 7/8 data bits, none/odd/even parity, 1/2 stop bits.
module rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       data_in,
  input  logic       stop_bits,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);

  rx_state_t        state;
  uart_cfg_t        cfg;
  logic [1:0]       sync;
  logic             line;
  logic             armed;
  logic [CNT_W-1:0] tcnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             ferr;
  logic             tick;
  logic             tick_clear_c;
  logic [7:0]       data_c;
  logic             par_err_c;
  logic             last_data_c;
  logic             last_stop_c;

  assign line         = sync[1];
  assign tick_clear_c = (state == ST_IDLE);

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clock     (clock),
    .rst       (rst),
    .baud_rate (cfg.baud_rate),
    .clear     (tick_clear_c),
    .tick      (tick)
  );

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clock) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], data_in};
  end

  // Frame decode helpers from the latched configuration
  always_comb begin
    data_c      = (cfg.data_length == LEN_8) ? shreg : {1'b0, shreg[6:0]};
    par_err_c   = 1'b0;
    if (cfg.parity_type == PAR_ODD)  par_err_c = ~((^data_c) ^ par_bit);
    if (cfg.parity_type == PAR_EVEN) par_err_c =  ((^data_c) ^ par_bit);
    last_data_c = (bit_idx == ((cfg.data_length == LEN_8) ? 3'd7 : 3'd6));
    last_stop_c = (bit_idx == ((cfg.stop_bits == STOP_2) ? 3'd1 : 3'd0));
  end

  // Receive FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cfg          <= '0;
      armed        <= 1'b0;
      tcnt         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      ferr         <= 1'b0;
      data_out     <= '0;
      rx_active    <= 1'b0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (line) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= ST_START;
            cfg     <= '{stop_bits, data_length, parity_type, baud_rate};
            tcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ferr    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt == HALF) begin
              tcnt <= '0;
              if (line) begin
                state <= ST_IDLE;
              end else begin
                rx_active <= 1'b1;
                state     <= ST_DATA;
              end
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tcnt == FULL) begin
              tcnt           <= '0;
              shreg[bit_idx] <= line;
              if (last_data_c) begin
                bit_idx <= '0;
                state   <= parity_enabled(cfg.parity_type) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (tcnt == FULL) begin
              tcnt    <= '0;
              par_bit <= line;
              state   <= ST_STOP;
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tcnt == FULL) begin
              tcnt <= '0;
              if (last_stop_c) begin
                state        <= ST_DONE;
                rx_done      <= 1'b1;
                rx_active    <= 1'b0;
                data_out     <= data_c;
                parity_error <= par_err_c;
                frame_error  <= ferr | ~line;
              end else begin
                ferr    <= ferr | ~line;
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tcnt <= tcnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit using a scaled clock so every baud rate fits a short run.
module tb_rx_unit;

  localparam int unsigned CLK_HZ = 250000;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b1;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b00;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;

  int checks = 0;
  int failures = 0;

  // Clocks per bit at CLK_HZ: divisors 7, 3, 2, 1 times 16
  int bp_tab [4] = '{112, 48, 32, 16};

  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   dbl_cnt = 0;
  int   active_at_done = 0;
  logic done_prev = 1'b0;
  logic active_seen = 1'b0;

  rx_unit #(.CLK_FREQ(CLK_HZ), .OVERSAMPLE(16)) dut (
    .clock        (clock),
    .rst          (rst),
    .data_in      (data_in),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .parity_type  (parity_type),
    .baud_rate    (baud_rate),
    .data_out     (data_out),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  // Observe pulses away from the active edge
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (rx_active) active_seen = 1'b1;
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (rx_active) active_at_done = active_at_done + 1;
      if (done_prev) dbl_cnt = dbl_cnt + 1;
    end
    done_prev = rx_done;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b, input int bp);
    data_in = b;
    wait_clk(bp);
  endtask

  task automatic set_cfg(input logic [1:0] b, input logic len8, input logic [1:0] pc, input logic stop2);
    baud_rate   = b;
    data_length = len8;
    parity_type = pc;
    stop_bits   = stop2;
  endtask

  // Reference transmitter
  task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] pc,
                            input logic stop2, input logic par_flip, input logic last_stop,
                            input int bp);
    logic [7:0] dm;
    logic       p;
    int         n;
    n  = len8 ? 8 : 7;
    dm = len8 ? d : {1'b0, d[6:0]};
    drive_bit(1'b0, bp);
    for (int i = 0; i < n; i++) drive_bit(dm[i], bp);
    if (pc == 2'b01 || pc == 2'b10) begin
      p = (pc == 2'b01) ? ~(^dm) : (^dm);
      drive_bit(p ^ par_flip, bp);
    end
    if (stop2) drive_bit(1'b1, bp);
    drive_bit(last_stop, bp);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    data_in = 1'b1;
    wait_clk(3);
    checks++;
    if ({data_out, rx_active, rx_done, parity_error, frame_error} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 000",
               {data_out, rx_active, rx_done, parity_error, frame_error});
    end
    rst = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_8n1_9600;
    int n0, st, lat;
    set_cfg(2'b10, 1'b1, 2'b00, 1'b0);
    wait_clk(2);
    n0 = done_cnt;
    active_seen = 1'b0;
    st = cyc;
    send_frame(8'hAA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32);
    data_in = 1'b1;
    wait_clk(32);
    lat = done_cyc - st;
    checks++;
    if (done_cnt - n0 !== 1) begin failures++; $display("FAIL 8n1_done_count: got %0d want 1", done_cnt - n0); end
    checks++;
    if (data_out !== 8'hAA) begin failures++; $display("FAIL 8n1_data: got %h want aa", data_out); end
    checks++;
    if ({parity_error, frame_error} !== 2'b00) begin failures++; $display("FAIL 8n1_errors: got %b want 00", {parity_error, frame_error}); end
    checks++;
    if (active_seen !== 1'b1) begin failures++; $display("FAIL 8n1_active: got %b want 1", active_seen); end
    checks++;
    if (lat < 300 || lat > 316) begin failures++; $display("FAIL 8n1_latency: got %0d want 300..316 clocks", lat); end
  endtask

  task automatic test_odd_parity;
    int n0;
    set_cfg(2'b00, 1'b1, 2'b01, 1'b0);
    wait_clk(2);
    n0 = done_cnt;
    send_frame(8'h55, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 112);
    data_in = 1'b1;
    wait_clk(112);
    checks++;
    if (done_cnt - n0 !== 1) begin failures++; $display("FAIL odd_done_count: got %0d want 1", done_cnt - n0); end
    checks++;
    if ({data_out, parity_error, frame_error} !== {8'h55, 2'b00}) begin
      failures++;
      $display("FAIL odd_good: got %h/%b/%b want 55/0/0", data_out, parity_error, frame_error);
    end
    send_frame(8'h55, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 112);
    data_in = 1'b1;
    wait_clk(112);
    checks++;
    if ({data_out, parity_error, frame_error} !== {8'h55, 2'b10}) begin
      failures++;
      $display("FAIL odd_bad: got %h/%b/%b want 55/1/0", data_out, parity_error, frame_error);
    end
  endtask

  task automatic test_break_7e2;
    int n0, n1;
    set_cfg(2'b11, 1'b0, 2'b10, 1'b1);
    wait_clk(2);
    n0 = done_cnt;
    send_frame(8'h2A, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 16);
    checks++;
    if (done_cnt - n0 !== 1) begin failures++; $display("FAIL brk_done_count: got %0d want 1", done_cnt - n0); end
    checks++;
    if ({data_out, parity_error, frame_error} !== {8'h2A, 2'b01}) begin
      failures++;
      $display("FAIL brk_result: got %h/%b/%b want 2a/0/1", data_out, parity_error, frame_error);
    end
    n1 = done_cnt;
    active_seen = 1'b0;
    wait_clk(48);
    checks++;
    if ({active_seen, 1'b0} !== 2'b00 || done_cnt !== n1) begin
      failures++;
      $display("FAIL brk_no_restart: active_seen %b extra_done %0d want 0/0", active_seen, done_cnt - n1);
    end
    data_in = 1'b1;
    wait_clk(32);
  endtask

  task automatic test_glitch;
    int n0;
    set_cfg(2'b01, 1'b1, 2'b00, 1'b0);
    wait_clk(2);
    n0 = done_cnt;
    active_seen = 1'b0;
    data_in = 1'b0;
    wait_clk(9);
    data_in = 1'b1;
    wait_clk(96);
    checks++;
    if (active_seen !== 1'b0 || done_cnt !== n0) begin
      failures++;
      $display("FAIL glitch_ignored: active_seen %b dones %0d want 0/0", active_seen, done_cnt - n0);
    end
    checks++;
    if ({data_out, parity_error, frame_error} !== {8'h2A, 2'b01}) begin
      failures++;
      $display("FAIL glitch_hold: got %h/%b/%b want 2a/0/1", data_out, parity_error, frame_error);
    end
  endtask

  task automatic test_reset_midframe;
    int n0;
    set_cfg(2'b10, 1'b1, 2'b00, 1'b0);
    wait_clk(2);
    n0 = done_cnt;
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    checks++;
    if (rx_active !== 1'b1) begin failures++; $display("FAIL mid_active: got %b want 1", rx_active); end
    rst = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    data_in = 1'b1;
    checks++;
    if ({data_out, rx_active, rx_done, parity_error, frame_error} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h want 000",
               {data_out, rx_active, rx_done, parity_error, frame_error});
    end
    wait_clk(96);
    checks++;
    if (done_cnt !== n0) begin failures++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - n0); end
    send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32);
    data_in = 1'b1;
    wait_clk(32);
    checks++;
    if (done_cnt - n0 !== 1 || {data_out, parity_error, frame_error} !== {8'h3C, 2'b00}) begin
      failures++;
      $display("FAIL mid_next_frame: dones %0d data %h err %b%b want 1/3c/00",
               done_cnt - n0, data_out, parity_error, frame_error);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] d, exp;
    int n0;
    for (int b = 0; b < 4; b++)
      for (int p = 0; p < 4; p++)
        for (int l = 0; l < 2; l++)
          for (int s = 0; s < 2; s++) begin
            d = 8'($urandom);
            set_cfg(2'(b), 1'(l), 2'(p), 1'(s));
            wait_clk(2);
            n0 = done_cnt;
            send_frame(d, 1'(l), 2'(p), 1'(s), 1'b0, 1'b1, bp_tab[b]);
            data_in = 1'b1;
            wait_clk(bp_tab[b]);
            exp = (l == 1) ? d : {1'b0, d[6:0]};
            checks++;
            if (done_cnt - n0 !== 1 || data_out !== exp || {parity_error, frame_error} !== 2'b00) begin
              failures++;
              $display("FAIL loop b%0d p%0d l%0d s%0d: dones %0d data %h err %b%b want 1/%h/00",
                       b, p, l, s, done_cnt - n0, data_out, parity_error, frame_error, exp);
            end
          end
  endtask

  task automatic test_pulse_shape;
    checks++;
    if (dbl_cnt !== 0) begin failures++; $display("FAIL done_double: got %0d want 0", dbl_cnt); end
    checks++;
    if (active_at_done !== 0) begin failures++; $display("FAIL active_at_done: got %0d want 0", active_at_done); end
  endtask

  initial begin
    test_reset();
    test_8n1_9600();
    test_odd_parity();
    test_break_7e2();
    test_glitch();
    test_reset_midframe();
    test_loopback();
    test_pulse_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_unit.md
Name: rx_unit

Overview:
UART receiver, the counterpart to the existing transmitter on the same serial link. It recovers frames from the serial line at one of four baud rates using 16x oversampling. Supported frames: 7 or 8 data bits, LSB first; none, odd or even parity; 1 or 2 stop bits. It presents the received byte with parity and framing status to the system logic on the 50 MHz clock domain.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; sets the oversample divisors.
OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.

Ports:
clock  in  1  system clock, 50 MHz.
rst  in  1  synchronous reset, active-low.
data_in  in  1  serial line; idles high; asynchronous to clock.
stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
parity_type  in  2  00 = none, 01 = odd, 10 = even, 11 = none.
baud_rate  in  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
data_out  out  8  last received data; bit 7 is 0 for 7-bit frames.
rx_active  out  1  high from start-bit confirmation until rx_done.
rx_done  out  1  one-cycle pulse when a frame completes.
parity_error  out  1  parity mismatch on the last frame.
frame_error  out  1  a stop-bit sample was 0 on the last frame.

Behaviour:
- Reset (rst low at a clock edge): all outputs 0, FSM to IDLE, tick counter cleared, synchroniser flops set to 1. A reset mid-frame aborts the frame with no rx_done.
- data_in passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick generator: tick pulses once every DIV clocks, where DIV = round(CLK_FREQ / (baud * OVERSAMPLE)). Defaults: 1302, 651, 326, 163.
- Configuration inputs are latched on start detection. Changes during a frame do not affect that frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - Armed only after the synchronised line has been seen high.
  - A synchronised 0 while armed moves to START and clears the tick divider and bit-tick counter.
- START:
  - After OVERSAMPLE/2 ticks (mid-bit), resample the line.
  - 1: false start; return to IDLE with no outputs changed.
  - 0: assert rx_active and move to DATA.
- DATA:
  - Sample every OVERSAMPLE ticks, shifting LSB first.
  - After 7 or 8 samples, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - Sample one bit after OVERSAMPLE ticks.
  - Odd: data bits XOR parity bit must equal 1. Even: it must equal 0.
- STOP:
  - Sample 1 or 2 bits at OVERSAMPLE-tick spacing.
  - Any sample of 0 sets the frame error flag.
  - Leave STOP immediately after the last stop sample. Do not wait for the end of the stop bit.
- DONE (one cycle), on the clock after the final stop sample:
  - data_out, parity_error and frame_error update together.
  - rx_done = 1 and rx_active = 0 in this cycle.
  - Then return to IDLE, disarmed.
- Outputs hold their values until the next completed frame. rx_done is never high for 2 consecutive cycles.
- Break or low line after a frame: the frame reports frame_error = 1, and no new start is detected until the line returns high.
- Bit-counter wrap: the bit-tick counter is 4 bits for OVERSAMPLE = 16 and wraps 15→0 at each bit boundary. The sample point is count == OVERSAMPLE/2 - 1 relative to the re-centred start.

Decomposition:
- Package uart_pkg:
  - baud encodings and the divisor function/constants;
  - parity encodings (PAR_NONE, PAR_ODD, PAR_EVEN);
  - FSM state enum;
  - data-length and stop-bit encodings.
- The transmitter moves to the same package.
- One sub-module: uart_baud_tick, which takes clock, rst, baud_rate and clear, and outputs a tick pulse.

Test Plan:
- 9600 baud, 8N1, byte 0xAA (line: 0,0,1,0,1,0,1,0,1,1) → one rx_done pulse about 9.5 bit periods after the start edge; data_out = 0xAA; both errors 0; rx_active high during the frame.
- 2400 baud, 8 data bits, odd parity, 1 stop, 0x55, parity bit 1 → data_out = 0x55, parity_error = 0. Repeat with parity bit 0 → parity_error = 1 and data still 0x55.
- 19200 baud, 7 data bits, even parity, 2 stop, 0x2A; second stop bit driven 0 → data_out = 0x2A, frame_error = 1, one rx_done pulse. No restart until the line goes high.
- Glitch on the line, low for 3 bit-ticks at 4800 baud → no rx_active and no rx_done; line idle, outputs unchanged.
- Reset (rst = 0 for 2 cycles) in the middle of the data bits at 9600 → all outputs 0, no rx_done. A following 8N1 0x3C frame is received correctly.
- Loopback: transmitter output to data_in, looping all 4 baud rates × 4 parity codes × 7/8 bits × 1/2 stop bits with random data → every data_out matches the sent data (masked to 7 bits for 7-bit frames), with no errors.
